ball_motion_engine: RTL and testbench

//  Per-frame kinematics stage directly upstream of VGA_driver: holds position/velocity of
//  N_BALLS sprites, advances them once per frame_tick with elastic wall bounces, and drives
//  the packed sprite_row/sprite_col buses (top-left corner of each SPRITE_DIM box).

---
 rtl/physics_pkg.sv | 59 +++++
 rtl/axis_bounce.sv | 43 ++++
 rtl/ball_motion_engine.sv | 131 +++++++++++++
 tb/tb_ball_motion_engine.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/physics_pkg.sv
// Shared types, screen geometry and velocity helpers for the ball motion engine.
package physics_pkg;

    localparam int SCREEN_H   = 1200;
    localparam int SCREEN_W   = 1600;
    localparam int SPRITE_DIM = 127;
    localparam int MAX_ROW    = SCREEN_H - SPRITE_DIM;
    localparam int MAX_COL    = SCREEN_W - SPRITE_DIM;
    localparam int VMAX       = 63;
    localparam int VINIT_ROW  = 3;
    localparam int VINIT_COL  = 5;
    localparam int GRAVITY    = 1;

    typedef logic [10:0]        pos_row_t;
    typedef logic [11:0]        pos_col_t;
    typedef logic signed [7:0]  vel_t;

    typedef struct packed {
        pos_row_t row;
        pos_col_t col;
        vel_t     vrow;
        vel_t     vcol;
    } ball_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_COMMIT = 2'd2
    } engine_state_e;

    function automatic vel_t clamp_vel(input logic signed [8:0] v);
        logic signed [8:0] lim;
        lim = 9'(VMAX);
        if (v > lim) begin
            return vel_t'(lim);
        end else if (v < -lim) begin
            return vel_t'(-lim);
        end else begin
            return vel_t'(v);
        end
    endfunction

    // Negating in 9 bits cannot overflow, so -(-128) lands above VMAX and clamps there.
    function automatic vel_t neg_vel(input vel_t v);
        logic signed [8:0] n;
        n = -$signed({v[7], v});
        return clamp_vel(n);
    endfunction

    function automatic ball_t reset_ball(input int i);
        ball_t b;
        b.row  = pos_row_t'(100 + 200 * i);
        b.col  = pos_col_t'(100 + 300 * i);
        b.vrow = vel_t'(VINIT_ROW);
        b.vcol = (i % 2 == 1) ? vel_t'(-VINIT_COL) : vel_t'(VINIT_COL);
        return b;
    endfunction

endpackage

// File: rtl/axis_bounce.sv
// One-axis position step with elastic reflection off 0 and MAX.
module axis_bounce
    import physics_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int MAX   = 1073
) (
    input  logic [WIDTH-1:0] pos,
    input  vel_t             vel,
    output logic [WIDTH-1:0] pos_nxt,
    output vel_t             vel_nxt
);

    localparam logic signed [12:0] MAX_S     = 13'(MAX);
    localparam logic signed [12:0] TWO_MAX_S = 13'(2 * MAX);

    logic signed [12:0] sum_s;
    logic signed [12:0] refl_s;

    // Add, reflect off whichever wall was crossed, then clamp into range.
    always_comb begin
        sum_s   = $signed({{(13 - WIDTH){1'b0}}, pos}) + $signed({{5{vel[7]}}, vel});
        refl_s  = sum_s;
        vel_nxt = vel;
        if (sum_s < 13'sd0) begin
            refl_s  = -sum_s;
            vel_nxt = neg_vel(vel);
        end else if (sum_s > MAX_S) begin
            refl_s  = TWO_MAX_S - sum_s;
            vel_nxt = neg_vel(vel);
        end else begin
            refl_s  = sum_s;
        end
        if (refl_s < 13'sd0) begin
            pos_nxt = '0;
        end else if (refl_s > MAX_S) begin
            pos_nxt = WIDTH'(MAX_S);
        end else begin
            pos_nxt = WIDTH'(refl_s);
        end
    end

endmodule

// File: rtl/ball_motion_engine.sv
// Per-frame sprite kinematics with double-buffered outputs.
// Optional feature macro: BALL_GRAVITY_EN (adds gravity to row velocity each frame).
module ball_motion_engine
    import physics_pkg::*;
#(
    parameter int N_BALLS = 4,
    localparam int IDX_W  = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
    input  logic                          clock_162,
    input  logic                          rst,
    input  logic                          frame_tick,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [IDX_W-1:0]              load_idx,
    input  logic [10:0]                   load_row,
    input  logic [11:0]                   load_col,
    input  logic signed [7:0]             load_vrow,
    input  logic signed [7:0]             load_vcol,
    output logic [N_BALLS-1:0][10:0]      sprite_row,
    output logic [N_BALLS-1:0][11:0]      sprite_col,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);

    ball_t         shadow [N_BALLS];
    engine_state_e state;
    logic [IDX_W-1:0] idx;

    ball_t    cur;
    ball_t    upd_ball;
    ball_t    load_ball;
    vel_t     vrow_in;
    pos_row_t row_nxt;
    pos_col_t col_nxt;
    vel_t     vrow_nxt;
    vel_t     vcol_nxt;
    logic     load_ok;

    assign cur        = shadow[idx];
    assign load_ready = (state == ST_IDLE) && !frame_tick;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_COMMIT);
    assign load_ok    = (32'(load_idx) < N_BALLS);

    // Gravity is applied before the position add so a floor bounce reflects it.
    always_comb begin
`ifdef BALL_GRAVITY_EN
        if (cur.vrow >= vel_t'(VMAX - GRAVITY)) begin
            vrow_in = vel_t'(VMAX);
        end else begin
            vrow_in = cur.vrow + vel_t'(GRAVITY);
        end
`else
        vrow_in = cur.vrow;
`endif
    end

    axis_bounce #(.WIDTH(11), .MAX(MAX_ROW)) u_row (
        .pos     (cur.row),
        .vel     (vrow_in),
        .pos_nxt (row_nxt),
        .vel_nxt (vrow_nxt)
    );

    axis_bounce #(.WIDTH(12), .MAX(MAX_COL)) u_col (
        .pos     (cur.col),
        .vel     (cur.vcol),
        .pos_nxt (col_nxt),
        .vel_nxt (vcol_nxt)
    );

    // Assemble the stepped ball and the clamped host-load ball.
    always_comb begin
        upd_ball.row   = row_nxt;
        upd_ball.col   = col_nxt;
        upd_ball.vrow  = vrow_nxt;
        upd_ball.vcol  = vcol_nxt;
        load_ball.row  = (load_row > pos_row_t'(MAX_ROW)) ? pos_row_t'(MAX_ROW) : load_row;
        load_ball.col  = (load_col > pos_col_t'(MAX_COL)) ? pos_col_t'(MAX_COL) : load_col;
        load_ball.vrow = clamp_vel({load_vrow[7], load_vrow});
        load_ball.vcol = clamp_vel({load_vcol[7], load_vcol});
    end

    // Frame sequencer: step one ball per cycle, then publish the shadow copy.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            for (int i = 0; i < N_BALLS; i++) begin
                shadow[i]     <= reset_ball(i);
                sprite_row[i] <= reset_ball(i).row;
                sprite_col[i] <= reset_ball(i).col;
            end
            state   <= ST_IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            if (frame_tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state <= ST_UPDATE;
                        idx   <= '0;
                    end else if (load_valid && load_ok) begin
                        shadow[load_idx] <= load_ball;
                    end
                end
                ST_UPDATE: begin
                    shadow[idx] <= upd_ball;
                    if (idx == IDX_W'(N_BALLS - 1)) begin
                        state <= ST_COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < N_BALLS; i++) begin
                        sprite_row[i] <= shadow[i].row;
                        sprite_col[i] <= shadow[i].col;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_engine.sv
// Self-checking bench: frame-level reference model plus directed literal expectations.
module tb_ball_motion_engine;

    localparam int N    = 4;
    localparam int MAXR = 1073;
    localparam int MAXC = 1473;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  frame_tick;
    logic                  load_valid;
    logic                  load_ready;
    logic [1:0]            load_idx;
    logic [10:0]           load_row;
    logic [11:0]           load_col;
    logic signed [7:0]     load_vrow;
    logic signed [7:0]     load_vcol;
    logic [N-1:0][10:0]    sprite_row;
    logic [N-1:0][11:0]    sprite_col;
    logic                  busy;
    logic                  frame_done;
    logic                  overrun;

    int checks = 0;
    int errors = 0;

    ball_motion_engine #(.N_BALLS(N)) dut (
        .clock_162  (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_row   (load_row),
        .load_col   (load_col),
        .load_vrow  (load_vrow),
        .load_vcol  (load_vcol),
        .sprite_row (sprite_row),
        .sprite_col (sprite_col),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: whole frame computed at the tick, published N+1 cycles later.
    int m_row[N], m_col[N], m_vr[N], m_vc[N];
    int e_row[N], e_col[N];
    int phase = 0;
    bit e_ovr = 1'b0;
    bit started = 1'b0;

    function automatic int negv(input int v);
        int n;
        n = -v;
        if (n > 127) n = 127;
        if (n > 63) n = 63;
        if (n < -63) n = -63;
        return n;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void bounce(input int mx, input int p0, input int v0,
                                   output int p, output int v);
        int n;
        n = p0 + v0;
        v = v0;
        if (n < 0) begin
            p = -n; v = negv(v0);
        end else if (n > mx) begin
            p = 2 * mx - n; v = negv(v0);
        end else begin
            p = n;
        end
        p = clampi(p, 0, mx);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_row[i] = 100 + 200 * i;
                m_col[i] = 100 + 300 * i;
                m_vr[i]  = 3;
                m_vc[i]  = (i % 2 == 1) ? -5 : 5;
                e_row[i] = m_row[i];
                e_col[i] = m_col[i];
            end
            phase = 0;
            e_ovr = 1'b0;
        end else if (started) begin
            if (phase != 0 && frame_tick) e_ovr = 1'b1;
            if (phase == N + 1) begin
                for (int i = 0; i < N; i++) begin
                    e_row[i] = m_row[i];
                    e_col[i] = m_col[i];
                end
                phase = 0;
            end else if (phase != 0) begin
                phase++;
            end else if (frame_tick) begin
                for (int i = 0; i < N; i++) begin
                    int vr, p, v;
                    vr = m_vr[i];
`ifdef BALL_GRAVITY_EN
                    vr = (vr + 1 > 63) ? 63 : vr + 1;
`endif
                    bounce(MAXR, m_row[i], vr, p, v);
                    m_row[i] = p; m_vr[i] = v;
                    bounce(MAXC, m_col[i], m_vc[i], p, v);
                    m_col[i] = p; m_vc[i] = v;
                end
                phase = 1;
            end else if (load_valid && int'(load_idx) < N) begin
                m_row[load_idx] = clampi(int'(load_row), 0, MAXR);
                m_col[load_idx] = clampi(int'(load_col), 0, MAXC);
                m_vr[load_idx]  = clampi(int'(load_vrow), -63, 63);
                m_vc[load_idx]  = clampi(int'(load_vcol), -63, 63);
            end
        end
    end

    // Compare process: every cycle after the first reset.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("sprite_row[%0d]", i), int'(sprite_row[i]), e_row[i]);
                chk($sformatf("sprite_col[%0d]", i), int'(sprite_col[i]), e_col[i]);
            end
            chk("busy", int'(busy), int'(phase != 0));
            chk("frame_done", int'(frame_done), int'(phase == N + 1));
            chk("overrun", int'(overrun), int'(e_ovr));
            chk("load_ready", int'(load_ready), int'(phase == 0 && !frame_tick));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input string name, input int dut_v, input int model_v, input int lit);
        chk({name, "_dut"}, dut_v, lit);
        chk({name, "_model"}, model_v, lit);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!frame_done && n < 20) begin
            cyc();
            n++;
        end
        if (n >= 20) chk("frame_done_timeout", 0, 1);
    endtask

    task automatic frame();
        int n;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        wait_done(n);
        cyc();
    endtask

    task automatic load(input int i, input int r, input int c, input int vr, input int vc);
        load_valid = 1'b1;
        load_idx   = 2'(i);
        load_row   = 11'(r);
        load_col   = 12'(c);
        load_vrow  = 8'(vr);
        load_vcol  = 8'(vc);
        cyc();
        load_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; frame_tick = 1'b0; load_valid = 1'b0;
        load_idx = 2'd0; load_row = 11'd0; load_col = 12'd0;
        load_vrow = 8'sd0; load_vcol = 8'sd0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        pin("rst_row1", int'(sprite_row[1]), e_row[1], 300);
        pin("rst_col3", int'(sprite_col[3]), e_col[3], 1000);

        // First frame and its latency.
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        wait_done(n);
        chk("latency", n, 4);
        cyc();
        pin("f1_row0", int'(sprite_row[0]), e_row[0], 103);
        pin("f1_col0", int'(sprite_col[0]), e_col[0], 105);
        pin("f1_col1", int'(sprite_col[1]), e_col[1], 395);

        // Top-wall reflection.
        load(0, 2, 500, -5, 0);
        frame();
        pin("top_row0", int'(sprite_row[0]), e_row[0], 3);
        frame();
        pin("top_row0_b", int'(sprite_row[0]), e_row[0], 8);

        // Right-wall reflection: 1470+10=1480 -> 2*1473-1480.
        load(2, 500, 1470, 0, 10);
        frame();
        pin("right_col2", int'(sprite_col[2]), e_col[2], 1466);
        frame();
        pin("right_col2_b", int'(sprite_col[2]), e_col[2], 1456);

        // -128 clamps to -63 on load.
        load(1, 0, 0, -128, 0);
        frame();
        pin("sat_row1", int'(sprite_row[1]), e_row[1], 63);
        frame();
        pin("sat_row1_b", int'(sprite_row[1]), e_row[1], 126);

        // Landing exactly on MAX / 0 does not bounce; position load clamps.
        load(3, 2000, 1463, 0, 10);
        frame();
        pin("clamp_row3", int'(sprite_row[3]), e_row[3], 1073);
        pin("edge_col3", int'(sprite_col[3]), e_col[3], 1473);
        frame();
        pin("edge_col3_b", int'(sprite_col[3]), e_col[3], 1463);
        load(0, 5, 0, -5, 0);
        frame();
        pin("edge_row0", int'(sprite_row[0]), e_row[0], 0);
        frame();
        pin("edge_row0_b", int'(sprite_row[0]), e_row[0], 5);

        // Second tick while busy is ignored and flags overrun.
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        wait_done(n);
        cyc(); cyc(); cyc();
        pin("ovr_flag", int'(overrun), int'(e_ovr), 1);
        pin("ovr_row0", int'(sprite_row[0]), e_row[0], 10);

        // Tick and load together in IDLE: tick wins.
        load_valid = 1'b1; load_idx = 2'd0; load_row = 11'd777;
        load_col = 12'd0; load_vrow = 8'sd0; load_vcol = 8'sd0;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0; load_valid = 1'b0;
        wait_done(n);
        cyc();
        pin("tickwin_row0", int'(sprite_row[0]), e_row[0], 15);

        // Reset in the second UPDATE cycle aborts the frame.
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (8) cyc();
        pin("abort_row0", int'(sprite_row[0]), e_row[0], 100);
        pin("abort_col3", int'(sprite_col[3]), e_col[3], 1000);
        pin("abort_ovr", int'(overrun), int'(e_ovr), 0);
        frame();
        pin("post_row0", int'(sprite_row[0]), e_row[0], 103);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
